// File: rtl/dmem_bridge_pkg.sv
// Shared types for the data-memory bridge: address/data types, FSM states,
// and the write-buffer entry layout.
package dmem_bridge_pkg;

    localparam int DMB_ADDR_W = 32;
    localparam int DMB_DATA_W = 32;

    typedef logic [DMB_ADDR_W-1:0] addr_t;
    typedef logic [DMB_DATA_W-1:0] data_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_DRAIN,
        RD_REQ,
        RD_WAIT,
        RD_DONE
    } dmb_state_e;

    typedef struct packed {
        addr_t addr;
        data_t data;
    } wbuf_entry_t;

    // States in which the write-buffer head may own the request bus.
    function automatic logic head_may_drive(input dmb_state_e s);
        return (s == IDLE) || (s == RD_DRAIN);
    endfunction

endpackage

// File: rtl/dmem_bridge_sync_fifo.sv
// Small synchronous FIFO with a combinational head (first-word fall-through).
// Storage is not reset; only pointers and occupancy are, so a reset flushes it.
module sync_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  T                           i_data,
    output T                           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_data  = mem_q[rd_ptr_q];
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    // Entry storage: written at the tail on an accepted push.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dmem_bridge.sv
// Bridge from a zero-wait core data-memory port to a valid/ready request bus
// with a separate read-response channel. Stores are posted into a write
// buffer; loads drain the buffer first, then stall the core until data returns.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int ADDR_W     = DMB_ADDR_W,
    parameter int DATA_W     = DMB_DATA_W,
    parameter int WBUF_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [ADDR_W-1:0] i_core_addr,
    input  logic [DATA_W-1:0] i_core_wd,
    input  logic              i_core_wen,
    input  logic              i_core_ren,
    output logic [DATA_W-1:0] o_core_rd,
    output logic              o_core_stall,
    output logic              o_bus_req_valid,
    input  logic              i_bus_req_ready,
    output logic              o_bus_req_we,
    output logic [ADDR_W-1:0] o_bus_req_addr,
    output logic [DATA_W-1:0] o_bus_req_wdata,
    input  logic              i_bus_rsp_valid,
    input  logic [DATA_W-1:0] i_bus_rsp_rdata
);

    localparam int CNT_W = $clog2(WBUF_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    dmb_state_e        state_q, state_d;
    logic [DATA_W-1:0] rd_q, rd_d;

    entry_t            push_entry;
    entry_t            head_entry;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    logic              rd_req;
    logic              head_drive;

    // A simultaneous store and load is illegal; it is handled as a store.
    assign rd_req     = i_core_ren && !i_core_wen;
    assign head_drive = head_may_drive(state_q) && !fifo_empty;
    assign push_entry = '{addr: i_core_addr, data: i_core_wd};
    assign o_core_rd  = rd_q;

    sync_fifo #(
        .DEPTH (WBUF_DEPTH),
        .T     (entry_t)
    ) u_wbuf (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_push  (fifo_push),
        .i_pop   (fifo_pop),
        .i_data  (push_entry),
        .o_data  (head_entry),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    // Next state, stall, write-buffer control and request-bus mux.
    always_comb begin
        state_d         = state_q;
        rd_d            = rd_q;
        o_core_stall    = 1'b0;
        o_bus_req_valid = 1'b0;
        o_bus_req_we    = 1'b0;
        o_bus_req_addr  = '0;
        o_bus_req_wdata = '0;
        fifo_push       = 1'b0;
        fifo_pop        = 1'b0;

        // Buffered writes own the bus whenever no read is in flight.
        if (head_drive) begin
            o_bus_req_valid = 1'b1;
            o_bus_req_we    = 1'b1;
            o_bus_req_addr  = head_entry.addr;
            o_bus_req_wdata = head_entry.data;
            fifo_pop        = i_bus_req_ready;
        end

        case (state_q)
            IDLE: begin
                if (i_core_wen) begin
                    // Fullness is the registered count: a pop this cycle does not help.
                    if (fifo_full) begin
                        o_core_stall = 1'b1;
                    end else begin
                        fifo_push = 1'b1;
                    end
                end else if (rd_req) begin
                    o_core_stall = 1'b1;
                    state_d      = fifo_empty ? RD_REQ : RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                // Earlier stores must reach the bus before the load is issued.
                o_core_stall = 1'b1;
                if (fifo_empty || (fifo_count == CNT_W'(1) && fifo_pop)) begin
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                // Core is held, so its address is stable for the whole request.
                o_core_stall    = 1'b1;
                o_bus_req_valid = 1'b1;
                o_bus_req_we    = 1'b0;
                o_bus_req_addr  = i_core_addr;
                if (i_bus_req_ready) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                o_core_stall = 1'b1;
                if (i_bus_rsp_valid) begin
                    rd_d    = i_bus_rsp_rdata;
                    state_d = RD_DONE;
                end
            end
            RD_DONE: begin
                // Core consumes rd_q this cycle; nothing new is issued here.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and captured load data.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
        end
    end

    // Protocol sanity: no store+load together, no response outside RD_WAIT.
    always_ff @(posedge i_clk) begin
        if (i_rstn) begin
            assert (!(i_core_wen && i_core_ren));
            assert (!(i_bus_rsp_valid && (state_q != RD_WAIT)));
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
module tb_dmem_bridge;

    localparam int DEPTH  = 4;
    localparam int BUDGET = 20000;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] core_addr, core_wd, core_rd;
    logic        core_wen, core_ren, core_stall;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    always #5 clk = ~clk;

    dmem_bridge #(.ADDR_W(32), .DATA_W(32), .WBUF_DEPTH(DEPTH)) dut (
        .i_clk           (clk),
        .i_rstn          (rstn),
        .i_core_addr     (core_addr),
        .i_core_wd       (core_wd),
        .i_core_wen      (core_wen),
        .i_core_ren      (core_ren),
        .o_core_rd       (core_rd),
        .o_core_stall    (core_stall),
        .o_bus_req_valid (req_valid),
        .i_bus_req_ready (req_ready),
        .o_bus_req_we    (req_we),
        .o_bus_req_addr  (req_addr),
        .o_bus_req_wdata (req_wdata),
        .i_bus_rsp_valid (rsp_valid),
        .i_bus_rsp_rdata (rsp_rdata)
    );

    // kind: 0 = nop, 1 = store, 2 = load
    typedef struct { int kind; logic [31:0] addr; logic [31:0] data; } instr_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;

    instr_t      prog[$];
    wr_t         exp_q[$];          // stores retired by the core, not yet seen on the bus
    logic [31:0] ref_mem [logic [31:0]];  // program-order memory image
    logic [31:0] slv_mem [logic [31:0]];  // memory image as updated by bus writes
    int          stall_cnt[$];
    int          last_wr_lat;
    int          n_rd;
    int          rsp_cnt;
    logic [31:0] rsp_addr;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : ~a;
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : ~a;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        ref_mem.delete();
        slv_mem.delete();
        rsp_cnt   = 0;
        rsp_valid = 1'b0;
    endtask

    // Plays prog on the core side and acts as bus slave; abort>0 stops after that many cycles.
    task automatic run_prog(input int hold, input int rdy_pct, input int max_dly, input int abort);
        int   pc   = 0;
        int   cyc  = 0;
        bit   done = 0;
        logic pv   = 1'b0;
        logic        p_we;
        logic [31:0] p_addr, p_wdata;
        stall_cnt.delete();
        foreach (prog[i]) stall_cnt.push_back(0);
        while (!done) begin
            req_ready = (cyc < hold) ? 1'b0 : ($urandom_range(99) < rdy_pct);
            rsp_valid = 1'b0;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    rsp_valid = 1'b1;
                    rsp_rdata = slv_rd(rsp_addr);
                end
            end
            if (pc < prog.size()) begin
                core_wen  = (prog[pc].kind == 1);
                core_ren  = (prog[pc].kind == 2);
                core_addr = prog[pc].addr;
                core_wd   = prog[pc].data;
            end else begin
                core_wen = 1'b0; core_ren = 1'b0; core_addr = '0; core_wd = '0;
            end
            #1;
            if (core_wen) chk("store_stall", core_stall, exp_q.size() == DEPTH);
            else if (!core_ren && pc < prog.size()) chk("nop_stall", core_stall, 0);
            if (pv) begin
                chk("hold_valid", req_valid, 1);
                chk("hold_we", req_we, p_we);
                chk("hold_addr", req_addr, p_addr);
                chk("hold_wdata", req_wdata, p_wdata);
            end
            pv = req_valid && !req_ready;
            p_we = req_we; p_addr = req_addr; p_wdata = req_wdata;
            if (req_valid && req_ready) begin
                if (req_we) begin
                    if (exp_q.size() == 0) chk("wr_unexpected", 1, 0);
                    else begin
                        chk("wr_addr", req_addr, exp_q[0].addr);
                        chk("wr_data", req_wdata, exp_q[0].data);
                        last_wr_lat = cyc - exp_q[0].cyc;
                        slv_mem[req_addr] = req_wdata;
                        void'(exp_q.pop_front());
                    end
                end else begin
                    chk("rd_after_drain", exp_q.size(), 0);
                    if (pc < prog.size() && prog[pc].kind == 2) chk("rd_addr", req_addr, prog[pc].addr);
                    else chk("rd_unexpected", 1, 0);
                    rsp_cnt  = $urandom_range(max_dly, 1);
                    rsp_addr = req_addr;
                    n_rd++;
                end
            end
            if (pc < prog.size()) begin
                if (core_stall) stall_cnt[pc]++;
                else begin
                    if (prog[pc].kind == 1) begin
                        exp_q.push_back('{addr: prog[pc].addr, data: prog[pc].data, cyc: cyc});
                        ref_mem[prog[pc].addr] = prog[pc].data;
                    end else if (prog[pc].kind == 2) begin
                        chk("load_data", core_rd, ref_rd(prog[pc].addr));
                    end
                    pc++;
                end
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (abort > 0) done = (cyc >= abort);
            else done = (pc >= prog.size() && exp_q.size() == 0 && rsp_cnt == 0) || cyc >= BUDGET;
        end
        if (abort == 0) chk("timeout", cyc < BUDGET, 1);
        core_wen = 1'b0; core_ren = 1'b0; rsp_valid = 1'b0;
    endtask

    task automatic reset_check();
        core_wen = 1'b0; core_ren = 1'b0; rsp_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("rst_valid", req_valid, 0);
        chk("rst_we", req_we, 0);
        chk("rst_addr", req_addr, 0);
        chk("rst_wdata", req_wdata, 0);
        chk("rst_stall", core_stall, 0);
        chk("rst_rd", core_rd, 0);
        @(negedge clk);
        rstn = 1'b1;
        model_clear();
        req_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("post_rst_idle", req_valid, 0);
        end
    endtask

    function automatic instr_t mk(input int k, input logic [31:0] a, input logic [31:0] d);
        instr_t t;
        t.kind = k; t.addr = a; t.data = d;
        return t;
    endfunction

    initial begin
        rstn = 1'b0;
        core_addr = '0; core_wd = '0; core_wen = 1'b0; core_ren = 1'b0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
        rsp_cnt = 0; n_rd = 0; last_wr_lat = 0;
        #1;
        chk("init_valid", req_valid, 0);
        chk("init_stall", core_stall, 0);
        chk("init_rd", core_rd, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // single posted store reaches the bus the cycle after it retires
        prog = '{mk(1, 32'h10, 32'hDEADBEEF)};
        run_prog(0, 100, 1, 0);
        chk("t1_stall", stall_cnt[0], 0);
        chk("t1_lat", last_wr_lat, 1);

        // five stores into a blocked bus: fifth waits for the first pop
        prog = '{mk(1, 32'h100, 32'h11), mk(1, 32'h104, 32'h22), mk(1, 32'h108, 32'h33),
                 mk(1, 32'h10C, 32'h44), mk(1, 32'h110, 32'h55)};
        run_prog(6, 100, 1, 0);
        for (int i = 0; i < 4; i++) chk("t2_nostall", stall_cnt[i], 0);
        chk("t2_5th_stall", stall_cnt[4], 3);

        // load with empty buffer: three stall cycles, one bus read
        n_rd = 0;
        slv_mem[32'h20] = 32'hCAFEF00D;
        ref_mem[32'h20] = 32'hCAFEF00D;
        prog = '{mk(2, 32'h20, 0)};
        run_prog(0, 100, 1, 0);
        chk("t3_stall", stall_cnt[0], 3);
        chk("t3_nrd", n_rd, 1);
        chk("t3_rd", core_rd, 32'hCAFEF00D);

        // stores then load to same address: program order preserved
        n_rd = 0;
        prog = '{mk(1, 32'h30, 32'h1), mk(1, 32'h30, 32'h2), mk(2, 32'h30, 0)};
        run_prog(0, 100, 1, 0);
        chk("t4_stall", stall_cnt[2], 4);
        chk("t4_nrd", n_rd, 1);
        chk("t4_rd", core_rd, 32'h2);

        // load with ready low for four cycles: request held stable
        prog = '{mk(2, 32'h40, 0)};
        run_prog(4, 100, 1, 0);
        chk("t6_stall", stall_cnt[0], 6);

        // randomized mix of stores, loads and nops over a small address set
        prog.delete();
        for (int i = 0; i < 400; i++) begin
            prog.push_back(mk($urandom_range(2), 32'($urandom_range(7)) << 2, $urandom));
        end
        run_prog(0, 70, 3, 0);

        // reset with two stores queued on a blocked bus
        prog = '{mk(1, 32'h50, 32'hA5A5), mk(1, 32'h54, 32'h5A5A)};
        run_prog(100, 0, 1, 2);
        reset_check();

        // reset while a read is outstanding
        prog = '{mk(2, 32'h60, 0)};
        run_prog(0, 100, 10, 3);
        reset_check();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
